// File: rtl/mem_access_unit_pkg.sv
// mips_mem_pkg: definitions shared by the memory-stage access engine and the
// load-alignment block (which the cache fill path will also use).
//   MEM_BYTE / MEM_HALF / MEM_WORD : MemSizeM encodings (2'b11 also means word)
//   memState_t                     : access FSM states
//   DEFAULT_TIMEOUT                : REQ cycles without ready before abort
//   isMisaligned()                 : alignment rule for a given size
package mips_mem_pkg;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } memState_t;

    // Halves need addr[0]=0; words need addr[1:0]=0. Size 2'b11 is a word.
    function automatic logic isMisaligned(input logic [1:0] addrLo, input logic [1:0] size);
        logic result;
        result = 1'b0;
        if (size == MEM_HALF) begin
            result = addrLo[0];
        end else if (size[1]) begin
            result = (addrLo != 2'b00);
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request/ready bus.
//   master modport: the access engine (drives request, address, data, strobes)
//   slave modport : the data memory (returns read data and completion)
//   DmemReq   : bus request, held until completion or abort
//   DmemWe    : write strobe
//   DmemAddr  : word-aligned byte address
//   DmemWdata : lane-replicated store data
//   DmemBe    : little-endian byte enables
//   DmemRdata : read data, valid together with DmemReady
//   DmemReady : completion, only meaningful while DmemReq is high
interface mem_access_unit_if;

    logic        DmemReq;
    logic        DmemWe;
    logic [31:0] DmemAddr;
    logic [31:0] DmemWdata;
    logic [3:0]  DmemBe;
    logic [31:0] DmemRdata;
    logic        DmemReady;

    modport master (
        output DmemReq, DmemWe, DmemAddr, DmemWdata, DmemBe,
        input  DmemRdata, DmemReady
    );

    modport slave (
        input  DmemReq, DmemWe, DmemAddr, DmemWdata, DmemBe,
        output DmemRdata, DmemReady
    );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// mem_load_align: purely combinational load formatter.
//   rdata      : raw 32-bit word from memory
//   addrLo     : byte offset within the word
//   size       : MEM_BYTE / MEM_HALF / word
//   isUnsigned : 1 = zero-extend, 0 = sign-extend
//   result     : selected lane, extended to 32 bits (words pass through)
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addrLo,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    output logic [31:0] result
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        unique case (addrLo)
            2'b00:   byteLane = rdata[7:0];
            2'b01:   byteLane = rdata[15:8];
            2'b10:   byteLane = rdata[23:16];
            default: byteLane = rdata[31:24];
        endcase
        halfLane = addrLo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        result = rdata;
        if (size == MEM_BYTE) begin
            result = {{24{byteLane[7] & ~isUnsigned}}, byteLane};
        end else if (size == MEM_HALF) begin
            result = {{16{halfLane[15] & ~isUnsigned}}, halfLane};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage data-access engine. Turns EX/MEM load/store
// controls into one request/ready bus transaction, steers store lanes,
// formats load data and stalls the pipeline until the result is ready.
//   clk, reset      : pipeline clock, async active-low reset
//   ALUOutM         : effective byte address
//   WriteDataM      : store data (low bits)
//   MemWriteM       : store request (wins if MemToRegM is also set)
//   MemToRegM       : load request
//   MemSizeM        : byte / half / word
//   MemUnsignedM    : zero-extend loads when 1
//   dmem            : data-memory bus (master side)
//   ReadDataM       : formatted load result, held through DONE
//   StallM          : hold IF..MEM while the access is in flight
//   MisalignM       : misaligned access seen in IDLE (no bus activity)
//   BusErrM         : access aborted after TIMEOUT REQ cycles
//
// state | meaning
// IDLE  | waiting for an aligned access; latches bus fields on accept
// REQ   | DmemReq high, waiting for DmemReady or timeout
// DONE  | result/error visible, stall released so the pipeline advances
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         ALUOutM,
    input  logic [31:0]         WriteDataM,
    input  logic                MemWriteM,
    input  logic                MemToRegM,
    input  logic [1:0]          MemSizeM,
    input  logic                MemUnsignedM,
    mem_access_unit_if.master   dmem,
    output logic [31:0]         ReadDataM,
    output logic                StallM,
    output logic                MisalignM,
    output logic                BusErrM
);

    memState_t          state;
    logic [CNT_W-1:0]   waitCnt;
    logic [1:0]         addrLoReg;
    logic [1:0]         sizeReg;
    logic               unsignedReg;

    logic               access;
    logic               misaligned;
    logic [3:0]         beNext;
    logic [31:0]        wdataNext;
    logic [31:0]        loadFmt;

    assign access     = MemWriteM | MemToRegM;
    assign misaligned = isMisaligned(ALUOutM[1:0], MemSizeM);

    // Gating with reset keeps both flags low while reset is held, even if
    // the pipeline is presenting an access.
    assign StallM    = reset & (((state == IDLE) & access & ~misaligned) | (state == REQ));
    assign MisalignM = reset & (state == IDLE) & access & misaligned;

    always_comb begin
        beNext    = 4'b1111;
        wdataNext = WriteDataM;
        if (MemSizeM == MEM_BYTE) begin
            beNext    = 4'b0001 << ALUOutM[1:0];
            wdataNext = {4{WriteDataM[7:0]}};
        end else if (MemSizeM == MEM_HALF) begin
            beNext    = ALUOutM[1] ? 4'b1100 : 4'b0011;
            wdataNext = {2{WriteDataM[15:0]}};
        end
    end

    // Lane selection uses the offset/size latched at accept, so the capture
    // does not depend on the pipeline holding EX/MEM steady.
    mem_load_align uLoadAlign (
        .rdata      (dmem.DmemRdata),
        .addrLo     (addrLoReg),
        .size       (sizeReg),
        .isUnsigned (unsignedReg),
        .result     (loadFmt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            waitCnt        <= '0;
            addrLoReg      <= 2'b00;
            sizeReg        <= 2'b00;
            unsignedReg    <= 1'b0;
            dmem.DmemReq   <= 1'b0;
            dmem.DmemWe    <= 1'b0;
            dmem.DmemAddr  <= 32'h0;
            dmem.DmemWdata <= 32'h0;
            dmem.DmemBe    <= 4'b0000;
            ReadDataM      <= 32'h0;
            BusErrM        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access && misaligned) begin
                        ReadDataM <= 32'h0;
                    end else if (access) begin
                        dmem.DmemReq   <= 1'b1;
                        dmem.DmemWe    <= MemWriteM;
                        dmem.DmemAddr  <= {ALUOutM[31:2], 2'b00};
                        dmem.DmemBe    <= beNext;
                        dmem.DmemWdata <= wdataNext;
                        addrLoReg      <= ALUOutM[1:0];
                        sizeReg        <= MemSizeM;
                        unsignedReg    <= MemUnsignedM;
                        ReadDataM      <= 32'h0;
                        BusErrM        <= 1'b0;
                        waitCnt        <= '0;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (dmem.DmemReady) begin
                        if (!dmem.DmemWe) begin
                            ReadDataM <= loadFmt;
                        end
                        dmem.DmemReq <= 1'b0;
                        state        <= DONE;
                    end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                        BusErrM      <= 1'b1;
                        ReadDataM    <= 32'h0;
                        dmem.DmemReq <= 1'b0;
                        state        <= DONE;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Memory-stage data-access engine of the pipelined MIPS core. It sits between the EX/MEM register outputs and the MEM/WB register. It turns load/store controls into a req/ready data-memory bus transaction and handles byte-lane steering and load alignment/extension. It stalls the pipeline until ReadDataM is valid for capture by the MEM/WB register.

Parameters:
TIMEOUT, 16, number of cycles in REQ without DmemReady before the access is aborted with BusErrM.
CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
ALUOutM  in  32  effective byte address
WriteDataM  in  32  store data (value in low bits)
MemWriteM  in  1  store request
MemToRegM  in  1  load request
MemSizeM  in  2  00 byte, 01 half, 10/11 word
MemUnsignedM  in  1  1 = zero-extend loads, 0 = sign-extend
DmemReq  out  1  bus request
DmemWe  out  1  bus write strobe
DmemAddr  out  32  word-aligned address ({addr[31:2],2'b00})
DmemWdata  out  32  lane-replicated store data
DmemBe  out  4  byte enables, little-endian
DmemRdata  in  32  bus read data, valid with DmemReady
DmemReady  in  1  bus completion, sampled only in REQ
ReadDataM  out  32  aligned, extended load result
StallM  out  1  hold IF..MEM stages
MisalignM  out  1  misaligned-access flag
BusErrM  out  1  timeout flag

Behaviour:
- Reset (reset=0, async): state IDLE. All registered outputs are 0: DmemReq, DmemWe, DmemAddr, DmemWdata, DmemBe, ReadDataM, MisalignM, BusErrM, counter. StallM is forced to 0.
- Access = MemWriteM | MemToRegM. If both are set, the access is a store and ReadDataM = 0.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - MisalignM = 1 combinationally in IDLE.
  - No bus request, no stall, ReadDataM = 0, state stays IDLE.
- FSM IDLE:
  - Aligned access: StallM = 1 (combinational).
  - Register DmemAddr, DmemWe, DmemBe and DmemWdata.
  - Clear the counter and BusErrM, then go to REQ.
  - No access: outputs hold, StallM = 0.
- FSM REQ:
  - DmemReq = 1, StallM = 1, and all bus outputs stay stable.
  - DmemReady = 1 (allowed on the first REQ cycle): on loads, capture formatted DmemRdata into ReadDataM. Go to DONE.
  - Otherwise increment the counter.
  - Counter reaches TIMEOUT-1 without ready: set BusErrM = 1, ReadDataM = 0, go to DONE.
- FSM DONE:
  - DmemReq = 0 and StallM = 0, so the pipeline advances at this edge.
  - ReadDataM and BusErrM hold through DONE. Go to IDLE.
- Latency:
  - Zero-wait access: StallM is high for 2 cycles and the result is valid in cycle 3.
  - Each wait cycle adds 1.
- Store lanes:
  - Byte: DmemBe = 1<<addr[1:0]; Wdata = byte replicated x4.
  - Half: DmemBe = 0011 (addr[1]=0) or 1100; Wdata = half replicated x2.
  - Word: DmemBe = 1111.
- Load format: select the byte/half lane by addr[1:0], then zero- or sign-extend per MemUnsignedM. Word loads pass through.
- DmemReady outside REQ is ignored.
- Async reset during REQ: DmemReq drops immediately. A late DmemReady after reset release is ignored.

Decomposition:
- Shared package mips_mem_pkg:
  - MemSize encodings (MEM_BYTE, MEM_HALF, MEM_WORD).
  - FSM state typedef {IDLE, REQ, DONE}.
  - Default TIMEOUT constant.
- One combinational sub-module mem_load_align: (rdata, addr[1:0], size, unsigned) -> 32-bit result. It is reused later by the cache fill path.
- Store-lane steering stays inline.

Test Plan:
- Store word at 0x100, data 0xDEADBEEF, ready on first REQ cycle -> DmemReq for 1 cycle, DmemAddr 0x100, DmemBe 1111, DmemWe 1, StallM high exactly 2 cycles.
- Signed byte load at 0x103, DmemRdata 0x80FF1234, ready immediate -> ReadDataM 0xFFFFFF80 in DONE. Repeat with MemUnsignedM=1 -> 0x00000080.
- Unsigned half load at 0x102, DmemRdata 0xBEEF0000, ready after 3 wait cycles -> ReadDataM 0x0000BEEF, StallM high 5 cycles. DmemAddr/DmemBe (1100) stable throughout REQ.
- Word load at 0x102 -> MisalignM 1, DmemReq never asserted, StallM 0, ReadDataM 0. Byte store at 0x101 with 0xAB -> DmemBe 0010, DmemWdata 0xABABABAB.
- Load with DmemReady held 0, TIMEOUT=16 -> 16 REQ cycles, then DONE with BusErrM 1, ReadDataM 0, StallM released. A following access clears BusErrM.
- Assert reset during the 2nd REQ cycle -> DmemReq and StallM go 0 without a clock edge. After release, a DmemReady pulse produces no capture and the state is IDLE.
